// File: rtl/xtea_pkg.sv
// Shared types and constants for the XTEA datapath: block/key types and round defaults.
package xtea_pkg;

  localparam logic [31:0] DELTA       = 32'h9e3779b9;
  localparam int          XTEA_ROUNDS = 32;

  typedef logic [63:0]  xtea_block_t;
  typedef logic [127:0] xtea_key_t;

endpackage

// File: rtl/xtea_block_fifo.sv
// DEPTH-entry block FIFO with a combinational head; push is ignored when full, pop when empty.
module xtea_block_fifo
  import xtea_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  xtea_block_t              push_data,
  input  logic                     pop,
  output xtea_block_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  xtea_block_t mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign head    = mem[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/xtea_feeder.sv
// Assembles 32-bit stream words into XTEA blocks/keys and issues one block per fixed slot.
// Optional stall_cnt output is enabled by defining XTEA_FEEDER_STALL_CNT_EN.
module xtea_feeder
  import xtea_pkg::*;
#(
  parameter int ROUNDS      = XTEA_ROUNDS,
  parameter int SLOT_CYCLES = ROUNDS + 3,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [31:0]              s_data,
  input  logic                     s_is_key,
  output logic [63:0]              in_enc,
  output logic [127:0]             key,
  output logic                     issue_valid,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef XTEA_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int SW = $clog2(SLOT_CYCLES);

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic          half_ptr_q, half_ptr_d;
  logic [31:0]   hi_word_q, hi_word_d;
  logic [1:0]    key_ptr_q, key_ptr_d;
  logic [95:0]   key_buf_q, key_buf_d;
  xtea_key_t     key_shadow_q, key_shadow_d;
  xtea_block_t   in_enc_q, in_enc_d;
  xtea_key_t     key_q, key_d;
  logic          issue_valid_q, issue_valid_d;

  logic          boundary;
  logic          data_take;
  logic          key_take;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  xtea_block_t   fifo_head;

  assign boundary = (slot_cnt_q == SW'(SLOT_CYCLES - 1));

  // Key words wait until every queued block has issued so no block picks up a newer key.
  assign s_ready   = s_is_key ? (fifo_empty && !half_ptr_q)
                              : !(fifo_full && half_ptr_q);
  assign data_take = s_valid && s_ready && !s_is_key;
  assign key_take  = s_valid && s_ready && s_is_key;
  assign push      = data_take && half_ptr_q;
  assign pop       = boundary && !fifo_empty;

  xtea_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data ({hi_word_q, s_data}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    slot_cnt_d    = boundary ? '0 : slot_cnt_q + SW'(1);
    half_ptr_d    = half_ptr_q;
    hi_word_d     = hi_word_q;
    key_ptr_d     = key_ptr_q;
    key_buf_d     = key_buf_q;
    key_shadow_d  = key_shadow_q;
    in_enc_d      = in_enc_q;
    key_d         = key_q;
    issue_valid_d = pop;

    if (data_take) begin
      if (!half_ptr_q) hi_word_d = s_data;
      half_ptr_d = !half_ptr_q;
    end

    if (key_take) begin
      case (key_ptr_q)
        2'd0:    key_buf_d[95:64] = s_data;
        2'd1:    key_buf_d[63:32] = s_data;
        2'd2:    key_buf_d[31:0]  = s_data;
        default: key_shadow_d     = {key_buf_q, s_data};
      endcase
      key_ptr_d = key_ptr_q + 2'd1;
    end

    if (pop) begin
      in_enc_d = fifo_head;
      key_d    = key_shadow_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt_q    <= '0;
      half_ptr_q    <= 1'b0;
      hi_word_q     <= '0;
      key_ptr_q     <= '0;
      key_buf_q     <= '0;
      key_shadow_q  <= '0;
      in_enc_q      <= '0;
      key_q         <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      half_ptr_q    <= half_ptr_d;
      hi_word_q     <= hi_word_d;
      key_ptr_q     <= key_ptr_d;
      key_buf_q     <= key_buf_d;
      key_shadow_q  <= key_shadow_d;
      in_enc_q      <= in_enc_d;
      key_q         <= key_d;
      issue_valid_q <= issue_valid_d;
    end
  end

  assign in_enc      = in_enc_q;
  assign key         = key_q;
  assign issue_valid = issue_valid_q;

`ifdef XTEA_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (boundary && fifo_empty && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
